// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared definitions for the instruction-fetch PC controller:
//               default widths and reset/halt values, and the fetch FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Default PC / branch-target width (word address)
    localparam int          PKG_PC_W      = 32;
    // Default PC loaded on reset
    localparam logic [31:0] PKG_RESET_PC  = 32'd0;
    // Default instruction word that stops fetch
    localparam logic [31:0] PKG_HALT_WORD = 32'h89AB_CDEF;

    // Width of the IF/ID flush down-counter (supports 1..7 flush cycles)
    localparam int          FLUSH_CNT_W   = 3;

    // Fetch FSM state encoding
    localparam logic [1:0]  c_RUN   = 2'd0;
    localparam logic [1:0]  c_STALL = 2'd1;
    localparam logic [1:0]  c_FLUSH = 2'd2;
    localparam logic [1:0]  c_HALT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fetch_flush_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_flush_counter
// Description : 3-bit down-counter that times the IF/ID flush window after a
//               redirect. Load has priority over decrement; decrement stops
//               at zero.
// Ports       : clk       - rising-edge clock
//               rst       - synchronous active-high reset (count -> 0)
//               i_load    - load i_loadVal
//               i_loadVal - reload value
//               i_dec     - decrement by one
//               o_done    - the next decrement takes the count to zero
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_flush_counter
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [FLUSH_CNT_W-1:0] i_loadVal,
    input  logic                   i_dec,
    output logic                   o_done
);

    logic [FLUSH_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - FLUSH_CNT_W'(1);
        end
    end

    // Flagged one cycle early so the FSM can leave FLUSH on the 1->0 edge
    assign o_done = (r_count == FLUSH_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/fetch_pc_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_controller
// Description : Instruction-fetch sequencer. Owns the word-addressed PC and
//               applies load-use stalls, branch redirects with IF/ID flush,
//               halt-sentinel detection and PC range checking. Counts the
//               instructions accepted into IF/ID.
// Ports       : clk           - rising-edge clock
//               reset         - synchronous active-high reset
//               stall_req     - load-use hazard; hold PC and IF/ID
//               branch_taken  - resolved branch/jump pulse
//               branch_target - redirect word address
//               instr_in      - instruction fetched for last cycle's PC
//               pc_out        - PC to the fetch unit (registered)
//               if_id_en      - IF/ID load enable
//               if_id_flush   - IF/ID clear (bubble)
//               halted        - fetch stopped (registered)
//               fault         - sticky out-of-range PC flag (registered)
//               fetch_count   - accepted-instruction count, wraps (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_controller
    import fetch_pkg::*;
#(
    parameter int               PC_W         = PKG_PC_W,
    parameter int unsigned      IMEM_DEPTH   = 32,
    parameter logic [PC_W-1:0]  RESET_PC     = PC_W'(PKG_RESET_PC),
    parameter int unsigned      FLUSH_CYCLES = 1,
    parameter logic [31:0]      HALT_WORD    = PKG_HALT_WORD
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_req,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic [31:0]     instr_in,
    output logic [PC_W-1:0] pc_out,
    output logic            if_id_en,
    output logic            if_id_flush,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    localparam logic [PC_W-1:0] c_DEPTH = PC_W'(IMEM_DEPTH);

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_postReset;
    logic            r_halted;
    logic            r_fault;
    logic [31:0]     r_fetchCount;

    logic [PC_W-1:0] w_pcPlus1;
    logic            w_seqFault;
    logic            w_tgtFault;
    logic            w_haltSeen;
    logic            w_ifIdEn;
    logic            w_ifIdFlush;
    logic            w_flushLoad;
    logic            w_flushDec;
    logic            w_flushDone;

    assign w_pcPlus1  = r_pc + PC_W'(1);
    // An all-ones PC wraps to 0 on increment; that wrap is itself a fault
    assign w_seqFault = (r_pc == '1) || (w_pcPlus1 >= c_DEPTH);
    assign w_tgtFault = (branch_target >= c_DEPTH);
    assign w_haltSeen = (instr_in == HALT_WORD);

    // The halt sentinel is bubbled out of IF/ID on the cycle it is seen,
    // and the first cycle after reset carries no valid instruction.
    assign w_ifIdEn    = (r_state == c_RUN) || (r_state == c_FLUSH);
    assign w_ifIdFlush = (r_state == c_FLUSH) ||
                         ((r_state == c_RUN) && (r_postReset || w_haltSeen));

    assign w_flushLoad = branch_taken && !w_tgtFault;
    assign w_flushDec  = (r_state == c_FLUSH) && !branch_taken && !w_seqFault;

    fetch_flush_counter u_flushCounter (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_flushLoad),
        .i_loadVal (FLUSH_CNT_W'(FLUSH_CYCLES)),
        .i_dec     (w_flushDec),
        .o_done    (w_flushDone)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_RUN;
            r_pc         <= RESET_PC;
            r_postReset  <= 1'b1;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_fetchCount <= 32'd0;
        end else begin
            r_postReset <= 1'b0;

            if (w_ifIdEn && !w_ifIdFlush) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end

            if (branch_taken) begin
                // Redirect wins over everything, including HALT: the halt
                // word may have been fetched down the wrong path.
                if (w_tgtFault) begin
                    r_fault  <= 1'b1;
                    r_state  <= c_HALT;
                    r_halted <= 1'b1;
                end else begin
                    r_pc     <= branch_target;
                    r_state  <= c_FLUSH;
                    r_halted <= 1'b0;
                end
            end else if (r_state != c_HALT) begin
                if (w_seqFault) begin
                    r_fault  <= 1'b1;
                    r_state  <= c_HALT;
                    r_halted <= 1'b1;
                end else if ((r_state == c_RUN) && w_haltSeen) begin
                    r_state  <= c_HALT;
                    r_halted <= 1'b1;
                end else if ((r_state != c_FLUSH) && stall_req) begin
                    r_state <= c_STALL;
                end else begin
                    r_pc <= w_pcPlus1;
                    if ((r_state != c_FLUSH) || w_flushDone) begin
                        r_state <= c_RUN;
                    end
                end
            end
        end
    end

    assign pc_out      = r_pc;
    assign if_id_en    = w_ifIdEn;
    assign if_id_flush = w_ifIdFlush;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign fetch_count = r_fetchCount;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_controller
// Description : Self-checking bench for fetch_pc_controller. Two instances
//               (1 and 3 flush cycles) share stimulus; a behavioural model
//               per instance is compared every cycle, with literal pins on
//               the single-flush instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_controller;

    localparam logic [31:0] HALTW = 32'h89AB_CDEF;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam longint unsigned DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_req = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] instr_in = NOP;

    logic [31:0] pcA, cntA, pcB, cntB;
    logic        enA, flA, hA, fA, enB, flB, hB, fB;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;

    always #5 clk = ~clk;

    fetch_pc_controller #(.FLUSH_CYCLES(1)) dutA (
        .clk(clk), .reset(reset), .stall_req(stall_req),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_in(instr_in), .pc_out(pcA), .if_id_en(enA),
        .if_id_flush(flA), .halted(hA), .fault(fA), .fetch_count(cntA)
    );

    fetch_pc_controller #(.FLUSH_CYCLES(3)) dutB (
        .clk(clk), .reset(reset), .stall_req(stall_req),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_in(instr_in), .pc_out(pcB), .if_id_en(enB),
        .if_id_flush(flB), .halted(hB), .fault(fB), .fetch_count(cntB)
    );

    // ---------------- behavioural model (one per instance) ----------------
    typedef enum int {M_RUN, M_STALL, M_FLUSH, M_HALT} mode_t;
    int          FL[2] = '{1, 3};
    mode_t       mMode[2] = '{M_RUN, M_RUN};
    logic [31:0] mPc[2]   = '{32'd0, 32'd0};
    int          mLeft[2] = '{0, 0};
    bit          mFirst[2] = '{1'b0, 1'b0};
    bit          mFault[2] = '{1'b0, 1'b0};
    logic [31:0] mCount[2] = '{32'd0, 32'd0};

    function automatic bit expEn(int k);
        return (mMode[k] == M_RUN) || (mMode[k] == M_FLUSH);
    endfunction

    function automatic bit expFlush(int k);
        return (mMode[k] == M_FLUSH) ||
               ((mMode[k] == M_RUN) && (mFirst[k] || instr_in == HALTW));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mMode[k] = M_RUN; mPc[k] = 32'd0; mLeft[k] = 0;
                mFirst[k] = 1'b1; mFault[k] = 1'b0; mCount[k] = 32'd0;
            end else begin
                if (expEn(k) && !expFlush(k)) mCount[k] = mCount[k] + 32'd1;
                mFirst[k] = 1'b0;
                if (branch_taken) begin
                    if (64'(branch_target) >= DEPTH) begin
                        mFault[k] = 1'b1; mMode[k] = M_HALT;
                    end else begin
                        mPc[k] = branch_target; mMode[k] = M_FLUSH; mLeft[k] = FL[k];
                    end
                end else if (mMode[k] != M_HALT) begin
                    if (64'(mPc[k]) + 64'd1 >= DEPTH) begin
                        mFault[k] = 1'b1; mMode[k] = M_HALT;
                    end else if (mMode[k] == M_RUN && instr_in == HALTW) begin
                        mMode[k] = M_HALT;
                    end else if (mMode[k] != M_FLUSH && stall_req) begin
                        mMode[k] = M_STALL;
                    end else begin
                        mPc[k] = mPc[k] + 32'd1;
                        if (mMode[k] == M_FLUSH) begin
                            mLeft[k] = mLeft[k] - 1;
                            if (mLeft[k] == 0) mMode[k] = M_RUN;
                        end else begin
                            mMode[k] = M_RUN;
                        end
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic checkDut(input int k, input logic [31:0] pc, input logic en,
                            input logic fl, input logic h, input logic f,
                            input logic [31:0] cnt);
        chk("pc_out", k, pc, mPc[k]);
        chk("if_id_en", k, 32'(en), 32'(expEn(k)));
        chk("if_id_flush", k, 32'(fl), 32'(expFlush(k)));
        chk("halted", k, 32'(h), 32'(mMode[k] == M_HALT));
        chk("fault", k, 32'(f), 32'(mFault[k]));
        chk("fetch_count", k, cnt, mCount[k]);
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkDut(0, pcA, enA, flA, hA, fA, cntA);
            checkDut(1, pcB, enB, flB, hB, fB, cntB);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input bit b, input logic [31:0] t,
                         input logic [31:0] ins);
        stall_req = s; branch_taken = b; branch_target = t; instr_in = ins;
    endtask

    typedef struct {bit s; bit b; logic [31:0] t; logic [31:0] ins;} vec_t;
    vec_t tbl[14] = '{
        '{1'b0, 1'b0, 32'd0,  NOP},  '{1'b1, 1'b0, 32'd0,  NOP},
        '{1'b1, 1'b0, 32'd0,  HALTW},'{1'b0, 1'b0, 32'd0,  NOP},
        '{1'b0, 1'b1, 32'd20, NOP},  '{1'b1, 1'b0, 32'd0,  HALTW},
        '{1'b1, 1'b0, 32'd0,  NOP},  '{1'b0, 1'b0, 32'd0,  NOP},
        '{1'b0, 1'b1, 32'd30, NOP},  '{1'b0, 1'b0, 32'd0,  NOP},
        '{1'b0, 1'b0, 32'd0,  NOP},  '{1'b1, 1'b0, 32'd0,  NOP},
        '{1'b0, 1'b0, 32'd0,  NOP},  '{1'b0, 1'b1, 32'd1,  NOP}
    };

    initial begin
        // Reset and free run
        step(1);
        reset = 1'b0;
        checkOn = 1'b1;
        chk("pin_reset_pc", 0, pcA, 32'd0);
        chk("pin_reset_flush", 0, 32'(flA), 32'd1);
        chk("pin_reset_count", 0, cntA, 32'd0);
        step(5);
        chk("pin_run_pc", 0, pcA, 32'd5);
        chk("pin_run_count", 0, cntA, 32'd4);

        // Two-cycle stall at pc=5
        drive(1, 0, 0, NOP); step(2);
        chk("pin_stall_pc", 0, pcA, 32'd5);
        chk("pin_stall_en", 0, 32'(enA), 32'd0);
        chk("pin_stall_count", 0, cntA, 32'd5);
        drive(0, 0, 0, NOP); step(1);
        chk("pin_unstall_pc", 0, pcA, 32'd6);

        // Branch with simultaneous stall
        drive(1, 1, 32'd10, NOP); step(1);
        chk("pin_branch_pc", 0, pcA, 32'd10);
        chk("pin_branch_flush", 0, 32'(flA), 32'd1);
        chk("pin_branch_count", 0, cntA, 32'd6);
        drive(0, 0, 0, NOP); step(1);
        chk("pin_after_flush_pc", 0, pcA, 32'd11);
        chk("pin_after_flush_fl", 0, 32'(flA), 32'd0);

        // Halt sentinel, then redirect out of HALT
        drive(0, 0, 0, HALTW); step(1);
        chk("pin_halt_h", 0, 32'(hA), 32'd1);
        chk("pin_halt_pc", 0, pcA, 32'd11);
        chk("pin_halt_count", 0, cntA, 32'd6);
        step(2);
        drive(0, 1, 32'd12, NOP); step(1);
        chk("pin_unhalt_h", 0, 32'(hA), 32'd0);
        chk("pin_unhalt_pc", 0, pcA, 32'd12);
        drive(0, 0, 0, NOP); step(1);

        // Run off the end of instruction memory
        drive(0, 1, 32'd30, NOP); step(1);
        drive(0, 0, 0, NOP); step(1);
        chk("pin_edge_pc", 0, pcA, 32'd31);
        step(1);
        chk("pin_fault_f", 0, 32'(fA), 32'd1);
        chk("pin_fault_h", 0, 32'(hA), 32'd1);
        chk("pin_fault_pc", 0, pcA, 32'd31);
        chk("pin_fault_count", 0, cntA, 32'd8);
        drive(0, 1, 32'd40, NOP); step(1);
        chk("pin_badtgt_pc", 0, pcA, 32'd31);
        drive(0, 1, 32'd5, NOP); step(1);
        chk("pin_sticky_fault", 0, 32'(fA), 32'd1);
        chk("pin_sticky_pc", 0, pcA, 32'd5);

        // Reset in the middle of a 3-cycle flush
        drive(0, 1, 32'd2, NOP); step(1);
        drive(0, 0, 0, NOP); step(1);
        reset = 1'b1; step(1);
        reset = 1'b0;
        chk("pin_midflush_pc", 1, pcB, 32'd0);
        chk("pin_midflush_fault", 1, 32'(fB), 32'd0);
        chk("pin_midflush_count", 1, cntB, 32'd0);
        step(3);
        chk("pin_postreset_pc", 1, pcB, 32'd3);

        // Reset out of HALT
        drive(0, 0, 0, HALTW); step(2);
        drive(0, 0, 0, NOP); reset = 1'b1; step(1);
        reset = 1'b0;
        chk("pin_halt_reset_h", 0, 32'(hA), 32'd0);
        step(2);

        // Mixed directed vectors, model-checked every cycle
        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].ins);
            step(1);
        end
        drive(0, 0, 0, NOP); step(4);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
